// File: rtl/alarm_pkg.sv
// Shared definitions for the alarm time keeper: FSM state type, alarm field
// widths and the seconds/minutes wrap limits.
package alarm_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    RINGING = 2'd2
  } state_t;

  localparam int unsigned SEC_W  = 6;
  localparam int unsigned MIN_W  = 6;
  localparam int unsigned HOUR_W = 5;
  localparam int unsigned RING_W = 7;

  localparam int unsigned SEC_MAX = 59;
  localparam int unsigned MIN_MAX = 59;

endpackage : alarm_pkg

// File: rtl/wrap_counter.sv
// Modulo-N up counter used for one alarm time field.
// Ports:
//   clk, reset : clock and asynchronous active-high reset
//   inc        : increment request, takes effect on the next rising edge
//   count      : registered field value, wraps MODULUS-1 -> 0
module wrap_counter #(
  parameter int unsigned MODULUS = 60,
  parameter int unsigned W       = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] LAST = W'(MODULUS - 1);

  // Field register with wrap at the modulus.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (inc) begin
      count <= (count == LAST) ? '0 : count + W'(1);
    end
  end

endmodule : wrap_counter

// File: rtl/alarm_time_keeper.sv
// Alarm clock core: holds an editable alarm time, compares it against the
// current time of day, and rings for a bounded number of 1 Hz ticks.
// Ports:
//   clk, reset                   : clock and asynchronous active-high reset
//   upsec, upmin, uphour         : single-cycle alarm field increment requests
//   alarm_en                     : level, 1 = alarm armed
//   stop_key                     : single-cycle pulse silencing a ringing alarm
//   tick_1hz                     : single-cycle pulse once per second
//   cur_sec, cur_min, cur_hour   : current time of day
//   alm_sec, alm_min, alm_hour   : stored alarm time (registered)
//   ringing                      : 1 while the alarm sounds (registered)
//   ring_left                    : ticks remaining in this ring, 0 when quiet
module alarm_time_keeper
  import alarm_pkg::*;
#(
  parameter int unsigned RING_SECONDS  = 60,
  parameter int unsigned HOURS_PER_DAY = 24
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              upsec,
  input  logic              upmin,
  input  logic              uphour,
  input  logic              alarm_en,
  input  logic              stop_key,
  input  logic              tick_1hz,
  input  logic [SEC_W-1:0]  cur_sec,
  input  logic [MIN_W-1:0]  cur_min,
  input  logic [HOUR_W-1:0] cur_hour,
  output logic [SEC_W-1:0]  alm_sec,
  output logic [MIN_W-1:0]  alm_min,
  output logic [HOUR_W-1:0] alm_hour,
  output logic              ringing,
  output logic [RING_W-1:0] ring_left
);

  localparam logic [RING_W-1:0] RING_LOAD = RING_W'(RING_SECONDS);

  state_t              state;
  state_t              state_n;
  logic                ringing_n;
  logic [RING_W-1:0]   ring_left_n;
  logic                match;
  logic                match_q;
  logic                match_rise;
  logic                edit_ok;

  // Edits are frozen while the alarm sounds.
  assign edit_ok = (state != RINGING);

  wrap_counter #(.MODULUS(SEC_MAX + 1), .W(SEC_W)) u_sec (
    .clk   (clk),
    .reset (reset),
    .inc   (upsec & edit_ok),
    .count (alm_sec)
  );

  wrap_counter #(.MODULUS(MIN_MAX + 1), .W(MIN_W)) u_min (
    .clk   (clk),
    .reset (reset),
    .inc   (upmin & edit_ok),
    .count (alm_min)
  );

  wrap_counter #(.MODULUS(HOURS_PER_DAY), .W(HOUR_W)) u_hour (
    .clk   (clk),
    .reset (reset),
    .inc   (uphour & edit_ok),
    .count (alm_hour)
  );

  // Only a fresh match may start a ring, so a held match after stop or
  // timeout stays silent. An alarm edit landing on the current time also
  // produces a fresh match.
  assign match      = (cur_sec == alm_sec) && (cur_min == alm_min) && (cur_hour == alm_hour);
  assign match_rise = match && !match_q;

  // State, match history and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      match_q   <= 1'b0;
      ringing   <= 1'b0;
      ring_left <= '0;
    end else begin
      state     <= state_n;
      match_q   <= match;
      ringing   <= ringing_n;
      ring_left <= ring_left_n;
    end
  end

  // Next state and next output values. Disarming beats stop, stop and the
  // final tick both land in ARMED.
  always_comb begin
    state_n     = state;
    ringing_n   = ringing;
    ring_left_n = ring_left;
    case (state)
      IDLE: begin
        if (alarm_en) begin
          state_n = ARMED;
        end
      end
      ARMED: begin
        if (!alarm_en) begin
          state_n = IDLE;
        end else if (match_rise) begin
          state_n     = RINGING;
          ringing_n   = 1'b1;
          ring_left_n = RING_LOAD;
        end
      end
      RINGING: begin
        if (!alarm_en) begin
          state_n     = IDLE;
          ringing_n   = 1'b0;
          ring_left_n = '0;
        end else if (stop_key || (tick_1hz && (ring_left <= RING_W'(1)))) begin
          state_n     = ARMED;
          ringing_n   = 1'b0;
          ring_left_n = '0;
        end else if (tick_1hz) begin
          ring_left_n = ring_left - RING_W'(1);
        end
      end
      default: begin
        state_n     = IDLE;
        ringing_n   = 1'b0;
        ring_left_n = '0;
      end
    endcase
  end

endmodule : alarm_time_keeper
